// File: rtl/prog_ctr.sv
// Program counter with an IDLE/RUN/DONE sequencer: absolute jumps, conditional
// relative branches, halt, stall, and a saturating retired-instruction count.
module prog_ctr #(
  parameter int PW = 10,
  parameter int OW = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Stall,
  input  logic                 Cond,
  input  logic                 BranchRel,
  input  logic                 Jump,
  input  logic                 Halt,
  input  logic signed [OW-1:0] Offset,
  input  logic        [PW-1:0] Target,
  output logic        [PW-1:0] ProgCtr,
  output logic                 Running,
  output logic                 Done,
  output logic        [15:0]   InstrCount
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_p0, state_nxt;
  logic [PW-1:0] pc_p0, pc_nxt;
  logic [15:0]   cnt_p0, cnt_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sign-extend the displacement past PW so the sum wraps modulo 2^PW.
  function automatic logic [PW-1:0] rel_add(input logic [PW-1:0] pc,
                                            input logic signed [OW-1:0] off);
    logic signed [PW+OW-1:0] ext;
    logic        [PW+OW-1:0] sum;
    ext = {{PW{off[OW-1]}}, off};
    sum = {{OW{1'b0}}, pc} + ext;
    return sum[PW-1:0];
  endfunction

  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    cnt_nxt   = cnt_p0;
    case (state_p0)
      IDLE: begin
        pc_nxt = '0;
        if (Start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!Stall) begin
          cnt_nxt = sat_inc(cnt_p0);
          if (Halt)                   state_nxt = DONE;
          else if (Jump)              pc_nxt = Target;
          else if (BranchRel && Cond) pc_nxt = rel_add(pc_p0, Offset);
          else                        pc_nxt = pc_p0 + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: architectural state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_p0 <= IDLE;
      pc_p0    <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign ProgCtr    = pc_p0;
  assign InstrCount = cnt_p0;
  assign Running    = (state_p0 == RUN);
  assign Done       = (state_p0 == DONE);

endmodule

// File: tb/tb_prog_ctr.sv
// Bench for prog_ctr: directed vectors, a behavioural model checked every cycle,
// and literal expectations at the key points.
module tb_prog_ctr;
  localparam int PW = 10;
  localparam int OW = 8;
  localparam int MOD = 1 << PW;

  logic                 Clk = 1'b0;
  logic                 Reset_n, Start, Stall, Cond, BranchRel, Jump, Halt;
  logic signed [OW-1:0] Offset;
  logic        [PW-1:0] Target;
  logic        [PW-1:0] ProgCtr;
  logic                 Running, Done;
  logic        [15:0]   InstrCount;

  int n_pass = 0;
  int n_total = 0;

  prog_ctr #(.PW(PW), .OW(OW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Cond(Cond),
    .BranchRel(BranchRel), .Jump(Jump), .Halt(Halt), .Offset(Offset),
    .Target(Target), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  // Model: phase 0=idle 1=run 2=done; pc and count as plain integers.
  int m_phase = 0;
  int m_pc = 0;
  int m_cnt = 0;
  bit m_ok = 1'b0;

  function automatic int wrap(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_phase <= 0; m_pc <= 0; m_cnt <= 0; m_ok <= 1'b1;
    end else if (m_phase != 1) begin
      if (Start) begin
        m_phase <= 1; m_pc <= 0; m_cnt <= 0;
      end
    end else if (!Stall) begin
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      if (Halt)                   m_phase <= 2;
      else if (Jump)              m_pc <= int'(Target);
      else if (BranchRel && Cond) m_pc <= wrap(m_pc + int'(Offset));
      else                        m_pc <= wrap(m_pc + 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge Clk) begin
    if (m_ok) begin
      chk("model_pc", int'(ProgCtr), m_pc);
      chk("model_cnt", int'(InstrCount), m_cnt);
      chk("model_running", int'(Running), (m_phase == 1) ? 1 : 0);
      chk("model_done", int'(Done), (m_phase == 2) ? 1 : 0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clr;
    Start = 0; Stall = 0; Cond = 0; BranchRel = 0; Jump = 0; Halt = 0;
    Offset = '0; Target = '0;
  endtask

  task automatic jump_to(input int a);
    Jump = 1; Target = PW'(a); cyc(); Jump = 0;
  endtask

  initial begin
    clr();
    Reset_n = 0;
    cyc(2);
    chk("rst_pc", int'(ProgCtr), 0);
    chk("rst_cnt", int'(InstrCount), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_done", int'(Done), 0);
    Reset_n = 1;
    cyc();
    chk("idle_pc", int'(ProgCtr), 0);

    Start = 1; cyc(); Start = 0;
    chk("start_pc", int'(ProgCtr), 0);
    chk("start_running", int'(Running), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("seq_pc", int'(ProgCtr), i);
    end
    chk("seq_cnt", int'(InstrCount), 5);
    chk("seq_running", int'(Running), 1);

    jump_to(20);
    chk("jump20", int'(ProgCtr), 20);
    BranchRel = 1; Offset = 8'shF6; Cond = 1; cyc(); clr();
    chk("br_taken_neg", int'(ProgCtr), 10);
    jump_to(20);
    BranchRel = 1; Offset = 8'shF6; Cond = 0; cyc(); clr();
    chk("br_not_taken", int'(ProgCtr), 21);
    BranchRel = 1; Offset = 8'sh7F; Cond = 1; cyc(); clr();
    chk("br_taken_pos", int'(ProgCtr), 148);
    jump_to(3);
    BranchRel = 1; Offset = 8'shF6; Cond = 1; cyc(); clr();
    chk("br_wrap_low", int'(ProgCtr), 1017);

    jump_to(1023);
    cyc();
    chk("seq_wrap", int'(ProgCtr), 0);
    jump_to(5);
    Jump = 1; Target = 10'd300; BranchRel = 1; Cond = 1; Offset = 8'sh04; cyc(); clr();
    chk("jump_over_branch", int'(ProgCtr), 300);
    chk("cnt_before_stall", int'(InstrCount), 16);

    Stall = 1; Halt = 1; Jump = 1; Target = 10'd7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", int'(ProgCtr), 300);
      chk("stall_cnt", int'(InstrCount), 16);
      chk("stall_running", int'(Running), 1);
    end
    Stall = 0; Jump = 0; cyc(); clr();
    chk("halt_done", int'(Done), 1);
    chk("halt_running", int'(Running), 0);
    chk("halt_pc", int'(ProgCtr), 300);
    chk("halt_cnt", int'(InstrCount), 17);
    Jump = 1; Target = 10'd9; cyc(2); clr();
    chk("done_hold_pc", int'(ProgCtr), 300);
    chk("done_hold_cnt", int'(InstrCount), 17);

    Start = 1; cyc();
    chk("restart_running", int'(Running), 1);
    chk("restart_pc", int'(ProgCtr), 0);
    chk("restart_cnt", int'(InstrCount), 0);
    cyc(); Start = 0;
    chk("start_in_run_pc", int'(ProgCtr), 1);
    chk("start_in_run_cnt", int'(InstrCount), 1);

    jump_to(37);
    chk("pc37", int'(ProgCtr), 37);
    Reset_n = 0; Start = 1; Jump = 1; Target = 10'd99; cyc();
    chk("midrun_rst_pc", int'(ProgCtr), 0);
    chk("midrun_rst_cnt", int'(InstrCount), 0);
    chk("midrun_rst_running", int'(Running), 0);
    chk("midrun_rst_done", int'(Done), 0);
    Reset_n = 1; clr(); cyc();
    chk("post_rst_idle", int'(Running), 0);
    Start = 1; cyc(); Start = 0;
    chk("post_rst_start_pc", int'(ProgCtr), 0);
    cyc(3);
    chk("post_rst_seq_pc", int'(ProgCtr), 3);

    cyc(65540);
    chk("cnt_saturated", int'(InstrCount), 65535);
    chk("sat_running", int'(Running), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
